// File: rtl/mul_dot_seq.sv
// mul_dot_seq: streaming front end and reduction back end for the shift-add
// multiplier. Operand pairs arrive over a valid/ready handshake; each pair is
// handed to the multiplier through its ena/accepted/complete protocol, and the
// products are summed into an unsigned accumulator. When the pair marked last
// has been multiplied, the dot product, element count and overflow flag are
// presented on a valid/ready result port.
//
// Build option: define MUL_DOT_SAT_EN to clamp the accumulator at all-ones on
// overflow; otherwise it wraps. res_ovf is sticky in both builds.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid/in_ready               operand pair handshake
//   in_a, in_b, in_last             unsigned operands, final-element marker
//   mul_ena, mul_a, mul_b           multiplier request and operands
//   mul_accepted, mul_complete      multiplier status
//   mul_out                         multiplier product
//   res_valid/res_ready             result handshake
//   res_sum, res_count, res_ovf     dot product, element count, overflow flag
//
// state  | meaning
// IDLE   | ready for a pair; captures it on in_valid
// ISSUE  | mul_ena high, waiting for mul_accepted
// WAIT   | mul_ena low, waiting for mul_complete; accumulates the product
// DONE   | result presented, held until res_ready

module mul_dot_seq #(
   parameter int WIDTH_A   = 8,
   parameter int WIDTH_B   = 8,
   parameter int WIDTH_ACC = 20,
   parameter int WIDTH_CNT = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         in_a,
   input  logic [WIDTH_B-1:0]         in_b,
   input  logic                       in_last,
   output logic                       mul_ena,
   output logic [WIDTH_A-1:0]         mul_a,
   output logic [WIDTH_B-1:0]         mul_b,
   input  logic                       mul_accepted,
   input  logic                       mul_complete,
   input  logic [WIDTH_A+WIDTH_B-1:0] mul_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH_ACC-1:0]       res_sum,
   output logic [WIDTH_CNT-1:0]       res_count,
   output logic                       res_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state;
   logic [WIDTH_A-1:0]   op_a;
   logic [WIDTH_B-1:0]   op_b;
   logic                 op_last;
   logic [WIDTH_ACC-1:0] acc;
   logic [WIDTH_CNT-1:0] cnt;
   logic                 ovf;
   logic [WIDTH_ACC:0]   sum_ext;
   logic                 carry;

   // One extra bit catches the carry out of the accumulator.
   assign sum_ext = {1'b0, acc} + (WIDTH_ACC+1)'(mul_out);
   assign carry   = sum_ext[WIDTH_ACC];

   assign in_ready  = (state == S_IDLE);
   assign mul_a     = op_a;
   assign mul_b     = op_b;
   assign res_sum   = acc;
   assign res_count = cnt;
   assign res_ovf   = ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_last   <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         mul_ena   <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_a    <= in_a;
                  op_b    <= in_b;
                  op_last <= in_last;
                  mul_ena <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mul_accepted) begin
                  mul_ena <= 1'b0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Only sampled here, so a complete left high by the previous
               // operation cannot be mistaken for this one.
               if (mul_complete) begin
`ifdef MUL_DOT_SAT_EN
                  if (ovf || carry) begin
                     acc <= '1;
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum_ext[WIDTH_ACC-1:0];
                  end
`else
                  acc <= sum_ext[WIDTH_ACC-1:0];
                  ovf <= ovf | carry;
`endif
                  if (!(&cnt))
                     cnt <= cnt + WIDTH_CNT'(1);
                  if (op_last) begin
                     res_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_dot_seq.sv
// Testbench for mul_dot_seq: two instances (default widths, and a 16-bit
// accumulator with a 2-bit counter) share one stimulus stream and one
// behavioural shift-add multiplier.
module tb_mul_dot_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_last = 1'b0;
   logic        res_ready = 1'b0;
   logic        inj = 1'b0;

   logic        in_ready, mul_ena, res_valid, res_ovf;
   logic [7:0]  mul_a, mul_b;
   logic [19:0] res_sum;
   logic [7:0]  res_count;

   logic        in_ready_s, mul_ena_s, res_valid_s, res_ovf_s;
   logic [7:0]  mul_a_s, mul_b_s;
   logic [15:0] res_sum_s;
   logic [1:0]  res_count_s;

   logic        mul_accepted, mul_complete;
   logic [15:0] mul_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_dot_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_ena(mul_ena), .mul_a(mul_a), .mul_b(mul_b),
      .mul_accepted(mul_accepted), .mul_complete(mul_complete), .mul_out(mul_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_count(res_count), .res_ovf(res_ovf)
   );

   mul_dot_seq #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_ACC(16), .WIDTH_CNT(2)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_ena(mul_ena_s), .mul_a(mul_a_s), .mul_b(mul_b_s),
      .mul_accepted(mul_accepted), .mul_complete(mul_complete), .mul_out(mul_out),
      .res_valid(res_valid_s), .res_ready(res_ready),
      .res_sum(res_sum_s), .res_count(res_count_s), .res_ovf(res_ovf_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Behavioural multiplier: loads on a rising ena, pulses accepted the next
   // cycle, then after k further cycles raises complete and leaves it high
   // until the next load. No reset, like the real one.
   function automatic int bitlen(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (v[i]) n = i + 1;
      return n;
   endfunction

   logic       m_ena_d = 1'b0, m_busy = 1'b0, m_acc = 1'b0, m_cmp = 1'b0;
   logic [7:0] m_a = '0, m_b = '0;
   int         m_rem = 0;
   logic [15:0] m_out = '0;

   always @(posedge clk) begin
      m_ena_d <= mul_ena;
      m_acc   <= 1'b0;
      if (mul_ena && !m_ena_d && !m_busy) begin
         m_busy <= 1'b1;
         m_acc  <= 1'b1;
         m_cmp  <= 1'b0;
         m_a    <= mul_a;
         m_b    <= mul_b;
         m_rem  <= (mul_a == 8'd0 || bitlen(mul_b) < 1) ? 0 : bitlen(mul_b) - 1;
      end else if (m_busy) begin
         if (m_rem == 0) begin
            m_busy <= 1'b0;
            m_cmp  <= 1'b1;
            m_out  <= 16'(m_a) * 16'(m_b);
         end else begin
            m_rem <= m_rem - 1;
         end
      end
   end

   assign mul_accepted = m_acc;
   assign mul_complete = m_cmp | inj;
   assign mul_out      = m_out;

   // ena must fall on the edge that samples accepted; count ena rising edges.
   logic p_ena = 1'b0, p_acc = 1'b0;
   int   ena_rises = 0;
   always @(posedge clk) begin
      #1;
      if (p_ena && p_acc && rst_n) check("ena_drop_after_accept", 32'(mul_ena), 32'd0);
      if (mul_ena && !p_ena) ena_rises++;
      p_ena = mul_ena;
      p_acc = mul_accepted;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick(1);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout_in_ready", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      tick(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_valid && n < 100) begin
         tick(1);
         n++;
      end
      if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic take_res(input logic [19:0] e_sum, input logic [7:0] e_cnt, input logic e_ovf,
                           input logic [15:0] s_sum, input logic [1:0] s_cnt, input logic s_ovf);
      wait_res();
      check("res_sum", 32'(res_sum), 32'(e_sum));
      check("res_count", 32'(res_count), 32'(e_cnt));
      check("res_ovf", 32'(res_ovf), 32'(e_ovf));
      check("s_res_valid", 32'(res_valid_s), 32'd1);
      check("s_res_sum", 32'(res_sum_s), 32'(s_sum));
      check("s_res_count", 32'(res_count_s), 32'(s_cnt));
      check("s_res_ovf", 32'(res_ovf_s), 32'(s_ovf));
      res_ready = 1'b1;
      tick(1);
      res_ready = 1'b0;
      check("res_valid_clear", 32'(res_valid), 32'd0);
      check("in_ready_after_take", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_mul_ena"}, 32'(mul_ena), 32'd0);
      check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
      check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
      check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_res_sum"}, 32'(res_sum), 32'd0);
      check({tag, "_res_count"}, 32'(res_count), 32'd0);
      check({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      int rises;
      tick(2);
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick(1);

      // Basic vector: 15 + 14 + 0 = 29; (3,5) takes k=2, capture at C+5
      send(8'd3, 8'd5, 1'b0);
      check("issue_in_ready", 32'(in_ready), 32'd0);
      check("issue_mul_ena", 32'(mul_ena), 32'd1);
      check("issue_mul_a", 32'(mul_a), 32'd3);
      check("issue_mul_b", 32'(mul_b), 32'd5);
      tick(4);
      check("wait_in_ready_c4", 32'(in_ready), 32'd0);
      tick(1);
      check("in_ready_after_capture", 32'(in_ready), 32'd1);
      send(8'd7, 8'd2, 1'b0);
      send(8'd0, 8'd255, 1'b1);
      take_res(20'd29, 8'd3, 1'b0, 16'd29, 2'd3, 1'b0);

      // Latency: (1,1) k=0
      send(8'd1, 8'd1, 1'b1);
      tick(2);
      check("lat11_rv_low_c2", 32'(res_valid), 32'd0);
      tick(2);
      check("lat11_rv_high_c4", 32'(res_valid), 32'd1);
      take_res(20'd1, 8'd1, 1'b0, 16'd1, 2'd1, 1'b0);

      // Latency: (1,255) k=7
      send(8'd1, 8'd255, 1'b1);
      tick(9);
      check("lat1ff_rv_low_c9", 32'(res_valid), 32'd0);
      tick(2);
      check("lat1ff_rv_high_c11", 32'(res_valid), 32'd1);
      take_res(20'd255, 8'd1, 1'b0, 16'd255, 2'd1, 1'b0);

      // Complete pulses in IDLE and ISSUE must not accumulate
      inj = 1'b1;
      tick(3);
      inj = 1'b0;
      send(8'd2, 8'd2, 1'b1);
      inj = 1'b1;
      tick(1);
      inj = 1'b0;
      take_res(20'd4, 8'd1, 1'b0, 16'd4, 2'd1, 1'b0);

      // Overflow on the 16-bit instance: 65025*2 = 130050
`ifdef MUL_DOT_SAT_EN
      send(8'd255, 8'd255, 1'b0);
      send(8'd255, 8'd255, 1'b1);
      take_res(20'd130050, 8'd2, 1'b0, 16'd65535, 2'd2, 1'b1);
`else
      send(8'd255, 8'd255, 1'b0);
      send(8'd255, 8'd255, 1'b1);
      take_res(20'd130050, 8'd2, 1'b0, 16'd64514, 2'd2, 1'b1);
`endif

      // Backpressure: hold result for 10 cycles with a pair waiting
      send(8'd5, 8'd6, 1'b1);
      wait_res();
      rises = ena_rises;
      in_valid = 1'b1;
      in_a = 8'd9;
      in_b = 8'd9;
      in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res_sum", 32'(res_sum), 32'd30);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      check("bp_no_new_ena", 32'(ena_rises), 32'(rises));
      take_res(20'd30, 8'd1, 1'b0, 16'd30, 2'd1, 1'b0);
      send(8'd2, 8'd3, 1'b1);
      take_res(20'd6, 8'd1, 1'b0, 16'd6, 2'd1, 1'b0);

      // Count saturation on the 2-bit counter
      for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
      send(8'd1, 8'd1, 1'b1);
      take_res(20'd5, 8'd5, 1'b0, 16'd5, 2'd3, 1'b0);

      // Reset while waiting on (255,255)
      send(8'd255, 8'd255, 1'b0);
      tick(4);
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_wait");
      tick(1);
      rst_n = 1'b1;
      tick(15);
      send(8'd4, 8'd4, 1'b1);
      take_res(20'd16, 8'd1, 1'b0, 16'd16, 2'd1, 1'b0);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_dot_seq.md
# mul_dot_seq

Sequencer and accumulator placed directly around the shift-add multiplier. It accepts a stream of operand pairs over a valid/ready handshake and drives the multiplier's ena/accepted/complete protocol one pair at a time. It sums the products into an unsigned accumulator and presents the dot product, with an element count and an overflow flag, when the element marked last has been multiplied. The block gives the multiplier a streaming front end and a reduction back end.

## Interface
- WIDTH_A, 8: operand A width; matches the multiplier's WIDTH_A.
- WIDTH_B, 8: operand B width; matches the multiplier's WIDTH_B.
- WIDTH_ACC, 20: accumulator width; must be ≥ WIDTH_A+WIDTH_B.
- WIDTH_CNT, 8: element counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can take a pair.
- in_a  in  WIDTH_A  operand A, unsigned.
- in_b  in  WIDTH_B  operand B, unsigned.
- in_last  in  1  pair is the final element of the vector.
- mul_ena  out  1  multiplier enable.
- mul_a  out  WIDTH_A  multiplier operand A.
- mul_b  out  WIDTH_B  multiplier operand B.
- mul_accepted  in  1  multiplier accepted signal.
- mul_complete  in  1  multiplier complete signal.
- mul_out  in  WIDTH_A+WIDTH_B  multiplier product.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer takes the result.
- res_sum  out  WIDTH_ACC  dot product.
- res_count  out  WIDTH_CNT  number of elements summed; saturates at all-ones.
- res_ovf  out  1  sticky flag: the accumulator overflowed during this vector.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: register in_a, in_b and in_last into op_a, op_b and op_last; go to ISSUE.
- **ISSUE**
  - mul_ena=1; mul_a and mul_b are driven from op_a and op_b.
  - When mul_accepted=1 is sampled, go to WAIT. mul_ena drops at that same edge.
- **WAIT**
  - mul_ena=0.
  - When mul_complete=1 is sampled:
    - acc ← acc + zero-extended mul_out.
    - count ← count+1 (saturating).
    - ovf is set on carry out of WIDTH_ACC.
  - Then go to DONE if op_last, else go to IDLE.
- **DONE**
  - res_valid=1; res_sum=acc, res_count=count, res_ovf=ovf, all held stable.
  - On res_ready: clear acc, count and ovf; go to IDLE.

Boundary conditions:
- in_ready=0 in ISSUE, WAIT and DONE. Only one element is ever in flight.
- in_last on the first element gives a one-element vector.
- A zero product still increments count.
- mul_complete is ignored outside WAIT. A stale complete left over from the previous operation is never sampled, because WAIT starts only after the multiplier has accepted the new pair.
- mul_ena is always low for at least one cycle between operations, so the multiplier sees a fresh rising edge of ena each time.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - Any multiplier operation in flight is abandoned; the multiplier has no reset.
  - The first ISSUE after reset comes no earlier than the second clock edge, so mul_accepted has already returned low.

## Timing
Reset values:
- State is IDLE; in_ready=1 (combinational from IDLE).
- mul_ena=0, mul_a=0, mul_b=0.
- res_valid=0, res_sum=0, res_count=0, res_ovf=0.

Per-element timing, with C the edge where IDLE captures the pair:
- ISSUE occupies C..C+2. The multiplier loads at C+1, and the FSM leaves ISSUE at C+2.
- The product is captured at C+3+k, where k = 0 if in_a=0, else max(0, bitlen(in_b)-1).
- in_ready is high again after C+3+k. Minimum 4 cycles per element.
- res_valid rises in the cycle after the capture of the last element.

## Configuration
- MUL_DOT_SAT_EN defined: on overflow, acc clamps to all-ones and stays there for the rest of the vector; res_ovf=1.
- MUL_DOT_SAT_EN undefined: acc wraps modulo 2^WIDTH_ACC; res_ovf=1 (sticky).

## Test plan
- Basic vector, defaults: (3,5), (7,2), (0,255,last) → res_sum=29, res_count=3, res_ovf=0.
- Latency: single pair (1,1,last) captured at edge C → res_valid high in cycle C+4..C+5. Pair (1,255,last) → res_valid high in cycle C+11..C+12.
- Overflow, WIDTH_ACC=16: (255,255), (255,255,last) → res_sum=64514 with res_ovf=1; with MUL_DOT_SAT_EN, res_sum=65535 with res_ovf=1.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → outputs stable, in_ready=0, no new mul_ena. A following vector (2,3,last) → 6, accumulator starting from 0.
- Reset in WAIT: assert rst_n=0 during (255,255) → all outputs at reset values immediately. After release, (4,4,last) → res_sum=16, res_count=1.
- Protocol: mul_ena never high in two consecutive operations without at least one low cycle between them. mul_complete pulses injected in IDLE or ISSUE → no accumulation.
